// File: rtl/decoder2to4_pulse.sv
// rtl/decoder2to4_pulse.sv - decodes {valid, idx} into a stretched one-hot pulse with drop counting
module decoder2to4_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_stb,
  input  logic [2:0]       code_in,
  output logic [3:0]       out,
  output logic             busy,
  output logic [1:0]       last_idx,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Counter reload leaves the accept cycle plus HOLD_CYCLES-1 further cycles high.
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_cnt_nxt;
  logic [3:0]       out_nxt;
  logic             busy_nxt;
  logic [1:0]       last_idx_nxt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic             valid_stb;

  // A null code (valid bit clear) never accepts and never counts as a drop.
  assign valid_stb = code_stb & code_in[2];

  // State and all outputs are registered; reset aborts any pulse at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      out      <= 4'b0000;
      busy     <= 1'b0;
      last_idx <= 2'b00;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      out      <= out_nxt;
      busy     <= busy_nxt;
      last_idx <= last_idx_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in HOLD, drop valid codes while holding.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    out_nxt      = out;
    busy_nxt     = busy;
    last_idx_nxt = last_idx;
    drop_cnt_nxt = drop_cnt;

    case (state)
      IDLE: begin
        if (valid_stb) begin
          last_idx_nxt = code_in[1:0];
          out_nxt      = 4'b0001 << code_in[1:0];
          busy_nxt     = 1'b1;
          hold_cnt_nxt = HOLD_INIT;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        // The final hold cycle still rejects, which guarantees an idle gap between pulses.
        if (valid_stb && (drop_cnt != CNT_MAX)) begin
          drop_cnt_nxt = drop_cnt + CNT_W'(1);
        end
        if (hold_cnt == 8'd0) begin
          out_nxt   = 4'b0000;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder2to4_pulse.sv
// tb/tb_decoder2to4_pulse.sv - scoreboard bench for decoder2to4_pulse across three parameter sets
module tb_decoder2to4_pulse;

  typedef struct {
    int         sel;
    int         id;
    logic [3:0] out;
    logic       busy;
    logic [1:0] last;
    logic [7:0] drop;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb [3];
  logic [2:0] code [3];

  logic [3:0] out_a, out_b, out_c;
  logic       busy_a, busy_b, busy_c;
  logic [1:0] last_a, last_b, last_c;
  logic [7:0] drop_a, drop_b;
  logic [1:0] drop_c;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  // Instance a: default parameters.
  decoder2to4_pulse #(.HOLD_CYCLES(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .code_stb(stb[0]), .code_in(code[0]),
    .out(out_a), .busy(busy_a), .last_idx(last_a), .drop_cnt(drop_a)
  );

  // Instance b: single-cycle pulse.
  decoder2to4_pulse #(.HOLD_CYCLES(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .code_stb(stb[1]), .code_in(code[1]),
    .out(out_b), .busy(busy_b), .last_idx(last_b), .drop_cnt(drop_b)
  );

  // Instance c: narrow counter for saturation.
  decoder2to4_pulse #(.HOLD_CYCLES(4), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .code_stb(stb[2]), .code_in(code[2]),
    .out(out_c), .busy(busy_c), .last_idx(last_c), .drop_cnt(drop_c)
  );

  task automatic push(input int sel, input logic [3:0] e_out, input logic e_busy,
                      input logic [1:0] e_last, input logic [7:0] e_drop);
    exp_t e;
    e.sel  = sel;
    e.id   = step_id;
    e.out  = e_out;
    e.busy = e_busy;
    e.last = e_last;
    e.drop = e_drop;
    sb.push_back(e);
    step_id++;
  endtask

  task automatic check_pop();
    exp_t       e;
    logic [3:0] o_out;
    logic       o_busy;
    logic [1:0] o_last;
    logic [7:0] o_drop;
    e = sb.pop_front();
    case (e.sel)
      0:       begin o_out = out_a; o_busy = busy_a; o_last = last_a; o_drop = drop_a; end
      1:       begin o_out = out_b; o_busy = busy_b; o_last = last_b; o_drop = drop_b; end
      default: begin o_out = out_c; o_busy = busy_c; o_last = last_c; o_drop = {6'd0, drop_c}; end
    endcase
    total++;
    assert (o_out === e.out) passed++;
    else $error("FAIL out inst%0d step%0d observed=%b expected=%b", e.sel, e.id, o_out, e.out);
    total++;
    assert (o_busy === e.busy) passed++;
    else $error("FAIL busy inst%0d step%0d observed=%b expected=%b", e.sel, e.id, o_busy, e.busy);
    total++;
    assert (o_last === e.last) passed++;
    else $error("FAIL last_idx inst%0d step%0d observed=%0d expected=%0d", e.sel, e.id, o_last, e.last);
    total++;
    assert (o_drop === e.drop) passed++;
    else $error("FAIL drop_cnt inst%0d step%0d observed=%0d expected=%0d", e.sel, e.id, o_drop, e.drop);
  endtask

  // Drive one cycle of stimulus on instance sel, expect the given state after the edge.
  task automatic cyc(input int sel, input logic s, input logic [2:0] c,
                     input logic [3:0] e_out, input logic e_busy,
                     input logic [1:0] e_last, input logic [7:0] e_drop);
    for (int i = 0; i < 3; i++) begin
      stb[i]  = 1'b0;
      code[i] = 3'b000;
    end
    stb[sel]  = s;
    code[sel] = c;
    push(sel, e_out, e_busy, e_last, e_drop);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      stb[i]  = 1'b0;
      code[i] = 3'b000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      push(i, 4'b0000, 1'b0, 2'd0, 8'd0);
      check_pop();
    end
    rst = 1'b0;

    // Single accept of idx 2, four cycles wide.
    cyc(0, 1'b1, 3'b110, 4'b0100, 1'b1, 2'd2, 8'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 3'b000, 4'b0100, 1'b1, 2'd2, 8'd0);
    cyc(0, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd2, 8'd0);
    cyc(0, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd2, 8'd0);

    // Encoder-style sequence at 20-cycle spacing.
    for (int k = 0; k < 4; k++) begin
      logic [2:0] c;
      logic [1:0] idx;
      logic [3:0] oh;
      c   = (k == 0) ? 3'b110 : 3'b111;
      idx = c[1:0];
      oh  = (k == 0) ? 4'b0100 : 4'b1000;
      cyc(0, 1'b1, c, oh, 1'b1, idx, 8'd0);
      for (int i = 0; i < 3; i++) cyc(0, 1'b0, 3'b000, oh, 1'b1, idx, 8'd0);
      for (int i = 0; i < 16; i++) cyc(0, 1'b0, 3'b000, 4'b0000, 1'b0, idx, 8'd0);
    end

    // Drops at hold cycle 2 and at the final hold cycle.
    cyc(0, 1'b1, 3'b101, 4'b0010, 1'b1, 2'd1, 8'd0);
    cyc(0, 1'b0, 3'b000, 4'b0010, 1'b1, 2'd1, 8'd0);
    cyc(0, 1'b1, 3'b100, 4'b0010, 1'b1, 2'd1, 8'd1);
    cyc(0, 1'b0, 3'b000, 4'b0010, 1'b1, 2'd1, 8'd1);
    cyc(0, 1'b1, 3'b100, 4'b0000, 1'b0, 2'd1, 8'd2);

    // Back-to-back accept in the first idle cycle; null code during hold is not a drop.
    cyc(0, 1'b1, 3'b111, 4'b1000, 1'b1, 2'd3, 8'd2);
    cyc(0, 1'b1, 3'b001, 4'b1000, 1'b1, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b000, 4'b1000, 1'b1, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b000, 4'b1000, 1'b1, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd3, 8'd2);

    // Null code and unstrobed code in idle.
    cyc(0, 1'b1, 3'b011, 4'b0000, 1'b0, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b111, 4'b0000, 1'b0, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b101, 4'b0000, 1'b0, 2'd3, 8'd2);

    // Async reset in the middle of a pulse, then a full-width pulse afterwards.
    cyc(0, 1'b1, 3'b111, 4'b1000, 1'b1, 2'd3, 8'd2);
    cyc(0, 1'b0, 3'b000, 4'b1000, 1'b1, 2'd3, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    push(0, 4'b0000, 1'b0, 2'd0, 8'd0);
    check_pop();
    #2;
    rst = 1'b0;
    cyc(0, 1'b1, 3'b110, 4'b0100, 1'b1, 2'd2, 8'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 3'b000, 4'b0100, 1'b1, 2'd2, 8'd0);
    cyc(0, 1'b0, 3'b000, 4'b0000, 1'b0, 2'd2, 8'd0);

    // HOLD_CYCLES=1: strobing every cycle accepts every other strobe.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'b1, 3'b100, 4'b0001, 1'b1, 2'd0, 8'(i));
      cyc(1, 1'b1, 3'b100, 4'b0000, 1'b0, 2'd0, 8'(i + 1));
    end

    // CNT_W=2: five drops saturate at 3.
    cyc(2, 1'b1, 3'b100, 4'b0001, 1'b1, 2'd0, 8'd0);
    cyc(2, 1'b1, 3'b101, 4'b0001, 1'b1, 2'd0, 8'd1);
    cyc(2, 1'b1, 3'b110, 4'b0001, 1'b1, 2'd0, 8'd2);
    cyc(2, 1'b1, 3'b111, 4'b0001, 1'b1, 2'd0, 8'd3);
    cyc(2, 1'b1, 3'b100, 4'b0000, 1'b0, 2'd0, 8'd3);
    cyc(2, 1'b1, 3'b110, 4'b0100, 1'b1, 2'd2, 8'd3);
    cyc(2, 1'b1, 3'b100, 4'b0100, 1'b1, 2'd2, 8'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decoder2to4_pulse.md
Name: decoder2to4_pulse

Overview:
- Receive-side counterpart of the 4-to-2 encoder: accepts the encoder's 3-bit code {valid, idx[1:0]} and regenerates a one-hot 4-bit line vector.
- Each decoded line is held high for a programmable number of cycles (pulse stretch).
- A two-state FSM tracks the hold window.
- Codes that arrive while a pulse is active are dropped and counted.
- Sits between the encoder output and downstream per-line consumers.

Parameters:
- HOLD_CYCLES, 4, number of cycles a decoded one-hot line stays high; legal range 1..255.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- code_stb  input  1  strobe; code_in is sampled only in cycles where this is 1.
- code_in  input  3  encoded request: bit2 = valid (any source active), bits1:0 = index of highest active source.
- out  output  4  one-hot decoded line vector, registered.
- busy  output  1  registered; 1 while a pulse is being held.
- last_idx  output  2  index of the most recently accepted code, registered.
- drop_cnt  output  CNT_W  saturating count of valid codes rejected while busy.

Behaviour:
- Reset (async, rst=1): out=4'b0000, busy=0, last_idx=2'b00, drop_cnt=0, state=IDLE, hold counter=0.
  - Outputs clear immediately on rst assertion, without waiting for a clock edge.
  - First possible accept is the first rising edge with rst=0.
- States:
  - IDLE: busy=0, out=0.
  - HOLD: busy=1, out=one-hot(last_idx).
- Accept condition: state==IDLE && code_stb==1 && code_in[2]==1.
  - On that edge: last_idx<=code_in[1:0]; out<=4'b0001<<code_in[1:0]; busy<=1; hold counter<=HOLD_CYCLES-1; state<=HOLD.
- Null code (code_stb=1, code_in[2]=0): ignored in every state.
  - No output change, no drop count.
  - code_in[1:0] is don't-care.
- code_stb=0: code_in is ignored entirely.
- HOLD timing:
  - Hold counter decrements by 1 each edge while nonzero.
  - On the edge where the counter is 0: out<=0, busy<=0, state<=IDLE.
  - Result: out is high for exactly HOLD_CYCLES consecutive cycles. HOLD_CYCLES=1 gives a single-cycle pulse.
- Latency: a code sampled at edge k appears on out from edge k through edge k+HOLD_CYCLES, i.e. one registered cycle after sampling.
- Drop rule: a valid strobe (code_stb=1, code_in[2]=1) in any HOLD cycle, including the final cycle, is dropped.
  - drop_cnt<=drop_cnt+1, saturating at all ones (no wrap).
  - out, last_idx and the hold counter are unaffected.
- Back-to-back: a valid strobe in the first IDLE cycle after HOLD exits is accepted.
  - Minimum spacing between accepted codes is HOLD_CYCLES+1 cycles, so out returns to 0 for at least one cycle between pulses.
- out is always 0 or exactly one-hot; never multi-hot.
- last_idx persists after the pulse ends until the next accept or reset.
- Reset mid-HOLD: pulse aborts immediately and all registers return to reset values. drop_cnt is also cleared.
- drop_cnt is never cleared except by rst.

Test Plan:
- Reset then single accept, HOLD_CYCLES=4: strobe code_in=3'b110 at edge 1 → out=4'b0100, busy=1, last_idx=2 for edges 1–4; out=0, busy=0 after edge 5.
- Encoder-driven sequence at HOLD_CYCLES=4, 20-cycle spacing, codes 3'b110, 3'b111, 3'b111, 3'b111 → pulses on out 4'b0100, 4'b1000, 4'b1000, 4'b1000, each 4 cycles wide; drop_cnt=0.
- Drop during hold: accept 3'b101, then valid strobes 3'b100 at hold cycles 2 and 4 (the final cycle) → out stays 4'b0010 for the full window; drop_cnt=2; last_idx=1.
- Null code and idle strobe: code_stb=1 with code_in=3'b011 in IDLE → out=0, busy=0, drop_cnt unchanged. Then code_stb=0 with code_in=3'b111 → no accept.
- Boundaries:
  - HOLD_CYCLES=1: strobe 3'b100 every cycle → out=4'b0001 on alternating cycles; every second strobe dropped.
  - CNT_W=2: five drops → drop_cnt saturates at 2'b11.
- Async reset mid-HOLD: assert rst between clock edges during a 3'b111 pulse → out=0, busy=0, drop_cnt=0 before the next edge. Then deassert and strobe 3'b110 → 4'b0100 pulse with full width.
